// File: rtl/fir_pkg.sv
// Shared definitions for the integer FIR datapath and its serial deconvolution
// filter: widths, default taps, FSM state type and output saturation.
package fir_pkg;

   localparam int unsigned FIR_N      = 4;
   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned IN_WIDTH   = DATA_WIDTH + 4;
   localparam int unsigned ACC_WIDTH  = IN_WIDTH + DATA_WIDTH + $clog2(FIR_N) + 1;
   localparam int unsigned ADDR_WIDTH = (FIR_N > 1) ? $clog2(FIR_N) : 1;

   typedef logic signed [DATA_WIDTH-1:0] tap_t;
   typedef logic [FIR_N-1:0][DATA_WIDTH-1:0] tap_arr_t;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

   typedef struct packed {
      logic sat;
      tap_t val;
   } sat_res_t;

   // Monic filter: h0 = 1 and h_i = i + 1 for the programmable taps.
   function automatic tap_arr_t default_taps();
      tap_arr_t t;
      for (int unsigned i = 0; i < FIR_N; i++) begin
         t[i] = DATA_WIDTH'(i + 1);
      end
      return t;
   endfunction

   localparam tap_arr_t FIR_DEF_TAPS = default_taps();

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(2 ** (DATA_WIDTH - 1) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

   function automatic sat_res_t saturate(input logic signed [ACC_WIDTH-1:0] a);
      sat_res_t r;
      r.sat = 1'b1;
      if (a > SAT_MAX) begin
         r.val = SAT_MAX[DATA_WIDTH-1:0];
      end else if (a < SAT_MIN) begin
         r.val = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         r.sat = 1'b0;
         r.val = a[DATA_WIDTH-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_deconv_serial_if.sv
// Stream and tap-programming signals of the serial deconvolution filter.
interface fir_deconv_serial_if;
   import fir_pkg::*;

   logic                         in_valid;
   logic                         in_ready;
   logic signed [IN_WIDTH-1:0]   y_in;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] x_out;
   logic                         sat;
   logic                         coef_wr;
   logic [ADDR_WIDTH-1:0]        coef_addr;
   logic signed [DATA_WIDTH-1:0] coef_data;
   logic                         hist_clr;

   modport master (
      output in_valid, y_in, out_ready, coef_wr, coef_addr, coef_data, hist_clr,
      input  in_ready, out_valid, x_out, sat
   );

   modport slave (
      input  in_valid, y_in, out_ready, coef_wr, coef_addr, coef_data, hist_clr,
      output in_ready, out_valid, x_out, sat
   );

endinterface

// File: rtl/fir_tap_regfile.sv
// Programmable taps h1..hN-1 with reset defaults; h0 reads back as the fixed 1.
module fir_tap_regfile
   import fir_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  tap_t                  wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output tap_t                  rd_data_o
);

   tap_t taps_q [1:FIR_N-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 1; i < FIR_N; i++) begin
            taps_q[i] <= FIR_DEF_TAPS[i];
         end
      end else if (wr_en_i && (wr_addr_i != '0) && (32'(wr_addr_i) < FIR_N)) begin
         taps_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_comb begin
      rd_data_o = (rd_addr_i == '0) ? tap_t'(1) : taps_q[rd_addr_i];
   end

endmodule

// File: rtl/fir_deconv_serial.sv
// All-pole inverse of the monic FIR: x[n] = y[n] - sum h_i*x[n-i], one shared multiplier.
// FIR_DECONV_SAT_EN: clip x_out to DATA_WIDTH and flag sat; otherwise two's-complement wrap.
module fir_deconv_serial
   import fir_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   fir_deconv_serial_if.slave bus
);

   state_e                        state_q, state_d;
   logic [ADDR_WIDTH-1:0]         k_q, k_d;
   logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
   tap_t                          hist_q [1:FIR_N-1];
   tap_t                          hist_d [1:FIR_N-1];
   tap_t                          h_k;
   logic signed [2*DATA_WIDTH-1:0] prod;
   sat_res_t                      res;
   logic                          out_now;

   fir_tap_regfile u_taps (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (bus.coef_wr && (state_q == IDLE)),
      .wr_addr_i (bus.coef_addr),
      .wr_data_i (bus.coef_data),
      .rd_addr_i (k_q),
      .rd_data_o (h_k)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         for (int unsigned i = 1; i < FIR_N; i++) begin
            hist_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         hist_q  <= hist_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      acc_d   = acc_q;
      hist_d  = hist_q;
      prod    = h_k * hist_q[k_q];
      case (state_q)
         IDLE: begin
            // Clear lands in the same edge as the accept, so MAC sees zero history.
            if (bus.hist_clr) begin
               for (int unsigned i = 1; i < FIR_N; i++) begin
                  hist_d[i] = '0;
               end
            end
            if (bus.in_valid) begin
               acc_d   = ACC_WIDTH'(bus.y_in);
               k_d     = ADDR_WIDTH'(1);
               state_d = (FIR_N > 1) ? MAC : OUT;
            end
         end
         MAC: begin
            acc_d = acc_q - ACC_WIDTH'(prod);
            if (k_q == ADDR_WIDTH'(FIR_N - 1)) begin
               state_d = OUT;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         OUT: begin
            // Feed back the presented value (clipped or wrapped), not the raw accumulator.
            if (bus.out_ready) begin
               hist_d[1] = res.val;
               for (int unsigned i = 2; i < FIR_N; i++) begin
                  hist_d[i] = hist_q[i-1];
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
`ifdef FIR_DECONV_SAT_EN
      res = saturate(acc_q);
`else
      res = '{sat: 1'b0, val: acc_q[DATA_WIDTH-1:0]};
`endif
      out_now       = (state_q == OUT);
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = out_now;
      bus.x_out     = out_now ? res.val : '0;
      bus.sat       = out_now & res.sat;
   end

endmodule

// File: doc/fir_deconv_serial.md
Name: fir_deconv_serial

Overview:
- Inverse (deconvolution) filter for the team's 4-tap integer FIR datapath. It recovers the original sample stream x[n] from the FIR output stream y[n].
- The FIR taps are monic (h0 = 1), so x[n] = y[n] − Σ_{i=1..N-1} h_i·x[n−i]. This is an all-pole IIR fed back from its own outputs.
- One multiplier is time-shared across taps under a small FSM, with valid/ready on both sides.
- Sits at the receive/analysis end of the filter chain; tap registers are runtime-programmable.

Parameters:
- N, 4, number of taps including h0 (h0 fixed at 1, not stored).
- DATA_WIDTH, 8, width of the recovered sample x_out and of each stored tap.
- IN_WIDTH, DATA_WIDTH+4, width of the FIR output sample y_in.
- ACC_WIDTH, IN_WIDTH+DATA_WIDTH+$clog2(N)+1, internal accumulator width; no internal overflow.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  y_in valid
- in_ready  out  1  block can accept y_in
- y_in  in  IN_WIDTH  signed FIR output sample
- out_valid  out  1  x_out valid
- out_ready  in  1  downstream accepts x_out
- x_out  out  DATA_WIDTH  signed recovered sample
- sat  out  1  x_out was clipped (valid with out_valid)
- coef_wr  in  1  tap write strobe
- coef_addr  in  $clog2(N)  tap index 1..N-1; writes to index 0 are ignored
- coef_data  in  DATA_WIDTH  signed tap value
- hist_clr  in  1  synchronous clear of the history (x[n−1..n−N+1])

Behaviour:
- Reset (async):
  - FSM goes to IDLE; in_ready=1, out_valid=0, x_out=0, sat=0.
  - History is cleared to 0; accumulator is cleared.
  - Taps h1..h3 load defaults 2, 3, 4; for general N, h_i = i+1.
- FSM has three states: IDLE → MAC → OUT → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: acc ← sign-extended y_in, tap index k ← 1, go to MAC.
- MAC:
  - in_ready=0. Each cycle acc ← acc − h_k·hist[k]; hist[k] = x[n−k].
  - After k = N−1, go to OUT. MAC lasts N−1 cycles.
- OUT:
  - out_valid=1; x_out = saturate(acc) to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - sat=1 if clipping occurred.
  - x_out and sat are held stable while out_ready=0.
  - On out_valid&&out_ready: history shifts (hist[1] ← x_out), return to IDLE.
  - The saturated value, not the raw acc, is fed back into history.
- Latency:
  - Input accepted at cycle 0 → out_valid at cycle N (N−1 MAC cycles plus one acc→OUT register cycle).
  - Max throughput is one sample per N+1 cycles.
- Arithmetic:
  - All operands are signed two's complement; products are full width.
  - The accumulator never wraps at the defaults.
- Tap writes:
  - Honoured only in IDLE.
  - Writes in MAC/OUT are dropped, so a sample is always computed with one consistent tap set.
  - A written tap is used by the next accepted sample.
- hist_clr:
  - Honoured only in IDLE; zeroes all history in one cycle.
  - If asserted with an input handshake in the same cycle, the clear applies first and the new sample sees zero history.
- N=1: MAC is skipped (IDLE→OUT) and x_out = sat(y_in).
- Reset mid-MAC/OUT: the pending sample is discarded and the output is not presented.

Optional Feature:
- Macro: FIR_DECONV_SAT_EN.
- Defined: saturating output as described above; sat asserted on clip.
- Undefined:
  - x_out = acc[DATA_WIDTH−1:0] (two's-complement wrap); sat is tied 0.
  - History stores the wrapped value.

Decomposition:
- Package fir_pkg holds:
  - localparams for DATA_WIDTH, IN_WIDTH, ACC_WIDTH;
  - a default tap array constant;
  - the FSM state enum typedef (IDLE, MAC, OUT);
  - a saturate function.
- The FIR filter and this block share fir_pkg.
- One natural sub-module, fir_tap_regfile: tap storage with reset defaults, IDLE-gated writes, and a combinational read port by k.

Test Plan:
- Impulse round trip: default taps, y_in = 1, 2, 3, 4, 0, 0 with out_ready=1 → x_out = 1, 0, 0, 0, 0, 0; sat=0; out_valid exactly N cycles after each accept.
- Step round trip: y_in = 5, 15, 30, 50, 50, 50 → x_out = 5, 5, 5, 5, 5, 5.
- Saturation:
  - Macro defined, cleared history, y_in = 200 → x_out = 127, sat=1.
  - Next y_in = 0 → x_out = −128 (0 − 2·127 = −254 clipped), sat=1.
  - Macro undefined: y_in = 200 → x_out = −56, sat=0.
- Backpressure: hold out_ready=0 for 10 cycles in OUT → x_out stable, in_ready=0, no input accepted; on release the history shifts exactly once.
- Tap write gating:
  - Write h1 = 0 during MAC → ignored; result matches default taps.
  - Write h1 = 0 in IDLE, then y_in = 1, 2 → x_out = 1, 2.
- Reset/clear:
  - Assert rst in the 2nd MAC cycle → out_valid=0 immediately; taps return to defaults; history is zero.
  - hist_clr with an input handshake in the same cycle → result equals sat(y_in).
